// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline boundary: valid/ready handshake, two-entry skid buffer, synchronous flush.
// MEM/WB control outputs are forced to zero whenever no valid entry is presented.
module ex_mem_pipe_reg #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int ALU_SIG_W    = 4,
    parameter int MEM_SIG_W    = 5,
    parameter int WB_SIG_W     = 5,
    parameter int MEMWRITE_BIT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    input  logic [XLEN-1:0]      pc_in,
    input  logic [XLEN-1:0]      inst_in,
    input  logic [XLEN-1:0]      imm_in,
    input  logic [XLEN-1:0]      aluout_in,
    input  logic [XLEN-1:0]      RD2_in,
    input  logic [ALU_SIG_W-1:0] alu_signal_in,
    input  logic [MEM_SIG_W-1:0] MEM_signal_in,
    input  logic [WB_SIG_W-1:0]  WB_signal_in,
    input  logic [REG_AW-1:0]    rd_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      pc_out,
    output logic [XLEN-1:0]      inst_out,
    output logic [XLEN-1:0]      imm_out,
    output logic [XLEN-1:0]      aluout_out,
    output logic [XLEN-1:0]      RD2_out,
    output logic [ALU_SIG_W-1:0] alu_signal_out,
    output logic [REG_AW-1:0]    rd_out,
    output logic [MEM_SIG_W-1:0] MEM_signal_out,
    output logic [WB_SIG_W-1:0]  WB_signal_out,
    output logic                 MemWrite_out,
    output logic [1:0]           occupancy
);

    // Bundle layout, LSB first: rd, WB, MEM, ALU, RD2, aluout, imm, inst, pc.
    localparam int RD_LSB     = 0;
    localparam int WB_LSB     = RD_LSB + REG_AW;
    localparam int MEM_LSB    = WB_LSB + WB_SIG_W;
    localparam int ALU_LSB    = MEM_LSB + MEM_SIG_W;
    localparam int RD2_LSB    = ALU_LSB + ALU_SIG_W;
    localparam int ALUOUT_LSB = RD2_LSB + XLEN;
    localparam int IMM_LSB    = ALUOUT_LSB + XLEN;
    localparam int INST_LSB   = IMM_LSB + XLEN;
    localparam int PC_LSB     = INST_LSB + XLEN;
    localparam int BUNDLE_W   = PC_LSB + XLEN;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic [BUNDLE_W-1:0]   main_r;
    logic [BUNDLE_W-1:0]   skid_r;
    logic [BUNDLE_W-1:0]   main_nx_s;
    logic [BUNDLE_W-1:0]   skid_nx_s;
    logic [BUNDLE_W-1:0]   in_bundle_s;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [1:0]            occupancy_r;
    logic [MEM_SIG_W-1:0]  mem_out_r;
    logic [WB_SIG_W-1:0]   wb_out_r;
    logic                  memwrite_r;
    logic                  in_fire_s;
    logic                  out_fire_s;
    logic                  valid_nx_s;
    logic                  in_ready_nx_s;
    logic [1:0]            occupancy_nx_s;
    logic [MEM_SIG_W-1:0]  mem_out_nx_s;
    logic [WB_SIG_W-1:0]   wb_out_nx_s;
    logic                  memwrite_nx_s;

    assign in_bundle_s = {pc_in, inst_in, imm_in, aluout_in, RD2_in,
                          alu_signal_in, MEM_signal_in, WB_signal_in, rd_in};
    assign in_fire_s   = in_valid & in_ready_r;
    assign out_fire_s  = out_valid_r & out_ready;

    // Next-state and storage selection; flush overrides the state but leaves stale data in place.
    always_comb begin
        state_nx_s = state_r;
        main_nx_s  = main_r;
        skid_nx_s  = skid_r;
        case (state_r)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    state_nx_s = ST_ONE;
                    main_nx_s  = in_bundle_s;
                end else begin
                    state_nx_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_fire_s && out_fire_s) begin
                    main_nx_s = in_bundle_s;
                end else if (in_fire_s) begin
                    state_nx_s = ST_FULL;
                    skid_nx_s  = in_bundle_s;
                end else if (out_fire_s) begin
                    state_nx_s = ST_EMPTY;
                end else begin
                    state_nx_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (out_fire_s) begin
                    state_nx_s = ST_ONE;
                    main_nx_s  = skid_r;
                end else begin
                    state_nx_s = ST_FULL;
                end
            end
            default: begin
                state_nx_s = ST_EMPTY;
            end
        endcase
        if (flush) begin
            state_nx_s = ST_EMPTY;
            main_nx_s  = main_r;
            skid_nx_s  = skid_r;
        end else begin
            state_nx_s = state_nx_s;
        end
    end

    // Handshake and bubble-masked control values for the next cycle, so every output is a flop.
    always_comb begin
        valid_nx_s    = (state_nx_s != ST_EMPTY);
        in_ready_nx_s = (state_nx_s != ST_FULL);
        case (state_nx_s)
            ST_EMPTY: occupancy_nx_s = 2'd0;
            ST_ONE:   occupancy_nx_s = 2'd1;
            ST_FULL:  occupancy_nx_s = 2'd2;
            default:  occupancy_nx_s = 2'd0;
        endcase
        if (valid_nx_s) begin
            mem_out_nx_s  = main_nx_s[MEM_LSB +: MEM_SIG_W];
            wb_out_nx_s   = main_nx_s[WB_LSB +: WB_SIG_W];
            memwrite_nx_s = main_nx_s[MEM_LSB + MEMWRITE_BIT];
        end else begin
            mem_out_nx_s  = {MEM_SIG_W{1'b0}};
            wb_out_nx_s   = {WB_SIG_W{1'b0}};
            memwrite_nx_s = 1'b0;
        end
    end

    // State, storage and registered output flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_EMPTY;
            main_r      <= {BUNDLE_W{1'b0}};
            skid_r      <= {BUNDLE_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            occupancy_r <= 2'd0;
            mem_out_r   <= {MEM_SIG_W{1'b0}};
            wb_out_r    <= {WB_SIG_W{1'b0}};
            memwrite_r  <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            main_r      <= main_nx_s;
            skid_r      <= skid_nx_s;
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= valid_nx_s;
            occupancy_r <= occupancy_nx_s;
            mem_out_r   <= mem_out_nx_s;
            wb_out_r    <= wb_out_nx_s;
            memwrite_r  <= memwrite_nx_s;
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = out_valid_r;
    assign occupancy      = occupancy_r;
    assign MEM_signal_out = mem_out_r;
    assign WB_signal_out  = wb_out_r;
    assign MemWrite_out   = memwrite_r;
    assign pc_out         = main_r[PC_LSB +: XLEN];
    assign inst_out       = main_r[INST_LSB +: XLEN];
    assign imm_out        = main_r[IMM_LSB +: XLEN];
    assign aluout_out     = main_r[ALUOUT_LSB +: XLEN];
    assign RD2_out        = main_r[RD2_LSB +: XLEN];
    assign alu_signal_out = main_r[ALU_LSB +: ALU_SIG_W];
    assign rd_out         = main_r[RD_LSB +: REG_AW];

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench for ex_mem_pipe_reg: default instance plus a 64-bit instance with a relocated store bit.
module tb_ex_mem_pipe_reg;

    logic        clk;
    logic        rst;
    int          errors;
    int          checks;

    logic        in_valid, in_ready, flush, out_valid, out_ready, MemWrite_out;
    logic [31:0] pc_in, inst_in, imm_in, aluout_in, RD2_in;
    logic [31:0] pc_out, inst_out, imm_out, aluout_out, RD2_out;
    logic [3:0]  alu_signal_in, alu_signal_out;
    logic [4:0]  MEM_signal_in, MEM_signal_out, WB_signal_in, WB_signal_out, rd_in, rd_out;
    logic [1:0]  occupancy;

    logic        v64_in, r64_in, v64_out, r64_out, mw64, flush64;
    logic [63:0] pc64_in, inst64_in, imm64_in, alu64_in, rd2_64_in;
    logic [63:0] pc64_out, inst64_out, imm64_out, alu64_out, rd2_64_out;
    logic [3:0]  alusig64_in, alusig64_out;
    logic [7:0]  mem64_in, mem64_out;
    logic [4:0]  wb64_in, wb64_out, rd64_in, rd64_out;
    logic [1:0]  occ64;

    ex_mem_pipe_reg dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .pc_in(pc_in), .inst_in(inst_in), .imm_in(imm_in), .aluout_in(aluout_in), .RD2_in(RD2_in),
        .alu_signal_in(alu_signal_in), .MEM_signal_in(MEM_signal_in), .WB_signal_in(WB_signal_in),
        .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .inst_out(inst_out), .imm_out(imm_out), .aluout_out(aluout_out),
        .RD2_out(RD2_out), .alu_signal_out(alu_signal_out), .rd_out(rd_out),
        .MEM_signal_out(MEM_signal_out), .WB_signal_out(WB_signal_out),
        .MemWrite_out(MemWrite_out), .occupancy(occupancy)
    );

    ex_mem_pipe_reg #(.XLEN(64), .MEM_SIG_W(8), .MEMWRITE_BIT(3)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64_in), .in_ready(r64_out), .flush(flush64),
        .pc_in(pc64_in), .inst_in(inst64_in), .imm_in(imm64_in), .aluout_in(alu64_in),
        .RD2_in(rd2_64_in), .alu_signal_in(alusig64_in), .MEM_signal_in(mem64_in),
        .WB_signal_in(wb64_in), .rd_in(rd64_in), .out_valid(v64_out), .out_ready(r64_in),
        .pc_out(pc64_out), .inst_out(inst64_out), .imm_out(imm64_out), .aluout_out(alu64_out),
        .RD2_out(rd2_64_out), .alu_signal_out(alusig64_out), .rd_out(rd64_out),
        .MEM_signal_out(mem64_out), .WB_signal_out(wb64_out), .MemWrite_out(mw64),
        .occupancy(occ64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got %h want 0", pc_out); end
        checks++; if (MemWrite_out !== 1'b0) begin errors++; $display("FAIL reset_memwrite got %b want 0", MemWrite_out); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc_in = pcs[i];
            tick();
            checks++; if (pc_out !== pcs[i]) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, pc_out, pcs[i]); end
            checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
                errors++; $display("FAIL stream_hs[%0d] got v=%b r=%b occ=%0d want 1 1 1", i, out_valid, in_ready, occupancy); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++; $display("FAIL stream_drain got v=%b occ=%0d want 0 0", out_valid, occupancy); end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; out_ready = 1'b1; pc_in = 32'h200;
        tick();
        out_ready = 1'b0; pc_in = 32'h204;
        tick();
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
            errors++; $display("FAIL skid_full got occ=%0d r=%b want 2 0", occupancy, in_ready); end
        checks++; if (pc_out !== 32'h200) begin errors++; $display("FAIL skid_head got %h want 200", pc_out); end
        pc_in = 32'h208;
        tick();
        checks++; if (pc_out !== 32'h200 || occupancy !== 2'd2) begin
            errors++; $display("FAIL skid_stall got pc=%h occ=%0d want 200 2", pc_out, occupancy); end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (pc_out !== 32'h204 || in_ready !== 1'b1 || occupancy !== 2'd1) begin
            errors++; $display("FAIL skid_pop got pc=%h r=%b occ=%0d want 204 1 1", pc_out, in_ready, occupancy); end
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            errors++; $display("FAIL skid_empty got v=%b occ=%0d want 0 0", out_valid, occupancy); end
    endtask

    task automatic test_flush_full();
        MEM_signal_in = 5'b00001; WB_signal_in = 5'h1F;
        in_valid = 1'b1; out_ready = 1'b0; pc_in = 32'h280;
        tick();
        pc_in = 32'h284;
        tick();
        checks++; if (occupancy !== 2'd2 || MemWrite_out !== 1'b1 || WB_signal_out !== 5'h1F) begin
            errors++; $display("FAIL flush_pre got occ=%0d mw=%b wb=%h want 2 1 1f", occupancy, MemWrite_out, WB_signal_out); end
        flush = 1'b1; pc_in = 32'h300;
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state got v=%b occ=%0d r=%b want 0 0 1", out_valid, occupancy, in_ready); end
        checks++; if (MemWrite_out !== 1'b0 || WB_signal_out !== 5'd0 || MEM_signal_out !== 5'd0) begin
            errors++; $display("FAIL flush_bubble got mw=%b wb=%h mem=%h want 0 0 0", MemWrite_out, WB_signal_out, MEM_signal_out); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || pc_out === 32'h300) begin
            errors++; $display("FAIL flush_drop got v=%b pc=%h want 0 and not 300", out_valid, pc_out); end
        MEM_signal_in = 5'd0; WB_signal_in = 5'd0;
    endtask

    task automatic test_store();
        MEM_signal_in = 5'b00001; RD2_in = 32'hDEADBEEF; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || MemWrite_out !== 1'b1 || RD2_out !== 32'hDEADBEEF) begin
            errors++; $display("FAIL store_fire got v=%b mw=%b rd2=%h want 1 1 deadbeef", out_valid, MemWrite_out, RD2_out); end
        MEM_signal_in = 5'b00010; RD2_in = 32'h0000_0001;
        tick();
        checks++; if (MemWrite_out !== 1'b0 || MEM_signal_out !== 5'b00010 || RD2_out !== 32'h1) begin
            errors++; $display("FAIL store_load got mw=%b mem=%b rd2=%h want 0 00010 1", MemWrite_out, MEM_signal_out, RD2_out); end
        MEM_signal_in = 5'b00001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || MemWrite_out !== 1'b0 || MEM_signal_out !== 5'd0) begin
            errors++; $display("FAIL store_bubble got v=%b mw=%b mem=%b want 0 0 0", out_valid, MemWrite_out, MEM_signal_out); end
        MEM_signal_in = 5'd0;
    endtask

    task automatic test_async_reset();
        MEM_signal_in = 5'b00001; in_valid = 1'b1; out_ready = 1'b0; pc_in = 32'h400;
        tick();
        pc_in = 32'h404;
        tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL areset_pre got occ=%0d want 2", occupancy); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL areset_hs got v=%b occ=%0d r=%b want 0 0 1", out_valid, occupancy, in_ready); end
        checks++; if (pc_out !== 32'h0 || MemWrite_out !== 1'b0 || MEM_signal_out !== 5'd0) begin
            errors++; $display("FAIL areset_data got pc=%h mw=%b mem=%h want 0 0 0", pc_out, MemWrite_out, MEM_signal_out); end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; MEM_signal_in = 5'd0;
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL areset_release got r=%b v=%b want 1 0", in_ready, out_valid); end
        in_valid = 1'b1; pc_in = 32'h500;
        tick();
        checks++; if (pc_out !== 32'h500 || occupancy !== 2'd1) begin
            errors++; $display("FAIL areset_restart got pc=%h occ=%0d want 500 1", pc_out, occupancy); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_param64();
        alu64_in = 64'hFFFF_0000_1234_5678; mem64_in = 8'b0000_1000; v64_in = 1'b1; r64_in = 1'b1;
        tick();
        checks++; if (alu64_out !== 64'hFFFF_0000_1234_5678) begin
            errors++; $display("FAIL p64_aluout got %h want ffff000012345678", alu64_out); end
        checks++; if (mw64 !== 1'b1 || mem64_out !== 8'b0000_1000) begin
            errors++; $display("FAIL p64_store got mw=%b mem=%b want 1 00001000", mw64, mem64_out); end
        alu64_in = 64'h8000_0000_0000_0001; mem64_in = 8'b0000_0001;
        tick();
        checks++; if (mw64 !== 1'b0 || alu64_out !== 64'h8000_0000_0000_0001) begin
            errors++; $display("FAIL p64_bit0 got mw=%b alu=%h want 0 8000000000000001", mw64, alu64_out); end
        v64_in = 1'b0;
        tick();
        checks++; if (v64_out !== 1'b0 || mw64 !== 1'b0 || mem64_out !== 8'd0) begin
            errors++; $display("FAIL p64_bubble got v=%b mw=%b mem=%h want 0 0 0", v64_out, mw64, mem64_out); end
    endtask

    initial begin
        errors = 0; checks = 0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        pc_in = 32'h0; inst_in = 32'h0000_0013; imm_in = 32'h4; aluout_in = 32'h55; RD2_in = 32'h0;
        alu_signal_in = 4'h2; MEM_signal_in = 5'd0; WB_signal_in = 5'd0; rd_in = 5'd7;
        v64_in = 1'b0; r64_in = 1'b0; flush64 = 1'b0;
        pc64_in = 64'h0; inst64_in = 64'h0; imm64_in = 64'h0; alu64_in = 64'h0; rd2_64_in = 64'h0;
        alusig64_in = 4'h0; mem64_in = 8'h0; wb64_in = 5'h0; rd64_in = 5'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_store();
        test_async_reset();
        test_param64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised next-generation EX/MEM pipeline boundary for the pipelined RISC-V core.
- Replaces the bare flop bank with a valid/ready handshake, a 2-entry skid buffer for MEM-side backpressure, synchronous flush and bubble-safe control outputs.
- Sits between the EX stage (ALU result, store data, control bundles) and the MEM stage (data memory, WB forwarding).

Parameters:
XLEN, 32, width of pc, inst, imm, ALU result and store data
REG_AW, 5, destination register index width
ALU_SIG_W, 4, ALU control bundle width
MEM_SIG_W, 5, MEM control bundle width
WB_SIG_W, 5, WB control bundle width
MEMWRITE_BIT, 0, index of the memory-write enable inside MEM_signal

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  EX presents a valid bundle
in_ready  out  1  block can accept; registered, no combinational path from out_ready
flush  in  1  synchronous kill of all held and incoming entries
pc_in, inst_in, imm_in, aluout_in, RD2_in  in  XLEN  EX datapath bundle
alu_signal_in  in  ALU_SIG_W  ALU control
MEM_signal_in  in  MEM_SIG_W  MEM control
WB_signal_in  in  WB_SIG_W  WB control
rd_in  in  REG_AW  destination register
out_valid  out  1  head entry valid
out_ready  in  1  MEM stage consumes head this cycle
pc_out, inst_out, imm_out, aluout_out, RD2_out, alu_signal_out, rd_out  out  matching  head entry datapath fields
MEM_signal_out  out  MEM_SIG_W  head MEM control, zero when !out_valid
WB_signal_out  out  WB_SIG_W  head WB control, zero when !out_valid
MemWrite_out  out  1  MEM_signal_out[MEMWRITE_BIT] qualified by out_valid
occupancy  out  2  entries held: 0, 1 or 2

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst low, asynchronous): state EMPTY; all data outputs 0; out_valid 0; MemWrite_out 0; occupancy 0; in_ready 1.
- Storage: main register drives the outputs; the skid register holds an overflow entry. Order is strict FIFO.
- State machine:
  - EMPTY: in_fire -> ONE, main <= input.
  - ONE: in_fire & out_fire -> ONE, main <= input. in_fire & !out_fire -> FULL, skid <= input. !in_fire & out_fire -> EMPTY. Otherwise hold.
  - FULL: in_ready is 0, so there is no in_fire. out_fire -> ONE, main <= skid. Otherwise hold.
- Handshake outputs:
  - in_ready = (state != FULL), decoded from the state register only.
  - out_valid = (state != EMPTY).
  - occupancy is 0 in EMPTY, 1 in ONE, 2 in FULL.
- Latency: input accepted in cycle N appears on the outputs with out_valid=1 in cycle N+1 when the block was EMPTY, or ONE with out_fire.
- Bubble safety: when out_valid=0, MEM_signal_out, WB_signal_out and MemWrite_out are forced to 0. Other data outputs hold their last value and are don't-care.
- Flush has priority over everything:
  - Next state is EMPTY and in_ready is 1 next cycle.
  - An input offered in the same cycle is dropped.
  - An out_fire in the same cycle still counts as consumed by MEM, but nothing is retained.
- Stall: out_ready held at 0 with out_valid=1 freezes all outputs bit-exact.
- Width rules: all fields are passed unmodified with no extension or truncation. MEMWRITE_BIT must be < MEM_SIG_W.
- Mid-operation reset: returns to the reset values immediately, independent of clk. The skid contents are lost.

Test Plan:
- Reset then stream: assert rst low, release; in_valid=1 with pc_in=0x100, 0x104, 0x108 and out_ready=1 -> out_valid from cycle 1, pc_out=0x100, 0x104, 0x108 on consecutive cycles; in_ready stays 1; occupancy stays 1.
- Backpressure and skid:
  - With the block in ONE, drop out_ready while sending 0x200 then 0x204 -> occupancy=2 and in_ready=0 the cycle after 0x204 is accepted; pc_out holds 0x200.
  - Raise out_ready -> pc_out=0x200, then 0x204; in_ready returns to 1.
- Flush while FULL: occupancy=2, flush=1 with in_valid=1 and pc_in=0x300 -> next cycle out_valid=0, occupancy=0, MemWrite_out=0, WB_signal_out=0; 0x300 is never output.
- Store qualification: MEM_signal_in=5'b00001, RD2_in=0xDEADBEEF -> MemWrite_out=1 and RD2_out=0xDEADBEEF only in cycles with out_valid=1. In the bubble cycle after consumption, MemWrite_out=0.
- Async reset mid-stall: occupancy=2, drive rst low between clock edges -> outputs zero before the next edge; in_ready=1 after release.
- Parameter sweep: XLEN=64, MEM_SIG_W=8, MEMWRITE_BIT=3, aluout_in=0xFFFF_0000_1234_5678 -> identical value on aluout_out; MemWrite_out follows bit 3.
